map_port_arbiter: RTL

- Shares the game map's single update read port and single update write port between N_REQ game-logic requesters (snake 1, snake 2, fruit spawner).
- Each requester gets an atomic read-modify-write (RMW) transaction on one cell. No other requester can touch the map between the read and the write.
- Sits between the game-logic engines and the map memory.
- The VGA render read port is separate and is not arbitrated here.

---
 rtl/map_pkg.sv | 39 +++
 rtl/rr_pick.sv | 35 +++
 rtl/map_port_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// map_pkg: shared map-side definitions for the game-logic update path.
// Holds the coordinate width, the 4-bit cell encoding, the update-port
// arbiter state enum and the packed cell-address payload.
package map_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned DATA_W  = 4;

  // Cell encoding: bit 3 marks a snake segment, bit 2 selects which snake,
  // bits [1:0] carry the tail direction.
  localparam logic [DATA_W-1:0] CELL_EMPTY = 4'b0000;
  localparam logic [DATA_W-1:0] CELL_OBST  = 4'b0001;
  localparam logic [DATA_W-1:0] CELL_FRUIT = 4'b0010;
  localparam int unsigned CELL_SNAKE_BIT = 3;
  localparam int unsigned CELL_ID_BIT    = 2;
  localparam int unsigned CELL_DIR_MSB   = 1;
  localparam int unsigned CELL_DIR_LSB   = 0;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    HOLD,
    WR,
    END
  } arb_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cell_addr_t;

  // True when the cell lies inside a w x h map.
  function automatic logic in_map(input cell_addr_t a, input int unsigned w,
                                  input int unsigned h);
    return (32'(a.x) < w) && (32'(a.y) < h);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational one-hot round-robin selector.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the highest-priority requester this round
//   grant - one-hot winner (all zero when no request)
module rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [2*N-1:0] back;
  logic           found;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    first = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
    back  = {{N{1'b0}}, first} << ptr;
    grant = back[N-1:0] | back[2*N-1:N];
  end

endmodule

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: shares the map update read and write ports between
// N_REQ game-logic requesters, giving each an atomic read-modify-write on
// one cell (or a write-only transaction).
// Ports:
//   clk, reset (async, active high)
//   req/req_x/req_y/req_wonly        - per-requester transaction request
//   cmd_commit/cmd_abort/cmd_wdata   - commands from the granted requester
//   grant, rsp_valid, rsp_data, done, err - requester-side responses
//   update_renable/rx/ry, update_rdata    - map read port
//   update_wenable/wx/wy/wdata            - map write port
// Optional: define MAP_ARB_TIMEOUT_EN to abort a HOLD that receives no
// command within TIMEOUT_CYC cycles (err and done pulse together).
module map_port_arbiter
  import map_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned MAPA_WIDTH  = 40,
  parameter int unsigned MAPA_HEIGHT = 30
`ifdef MAP_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*COORD_W-1:0] req_x,
  input  logic [N_REQ*COORD_W-1:0] req_y,
  input  logic [N_REQ-1:0]         req_wonly,
  input  logic [N_REQ-1:0]         cmd_commit,
  input  logic [N_REQ-1:0]         cmd_abort,
  input  logic [N_REQ*DATA_W-1:0]  cmd_wdata,
  output logic [N_REQ-1:0]         grant,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         err,
  output logic                     update_renable,
  output logic [COORD_W-1:0]       update_rx,
  output logic [COORD_W-1:0]       update_ry,
  input  logic [DATA_W-1:0]        update_rdata,
  output logic                     update_wenable,
  output logic [COORD_W-1:0]       update_wx,
  output logic [COORD_W-1:0]       update_wy,
  output logic [DATA_W-1:0]        update_wdata
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [N_REQ-1:0]  pick;
  cell_addr_t        sel_addr;
  cell_addr_t        lat_addr;
  logic              sel_wonly;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_map;
  logic              any_req;
  logic              hold_commit;
  logic              hold_abort;
  logic [DATA_W-1:0] hold_wdata;
  logic              hold_expired;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick)
  );

  // Fields of the round-robin winner and the pointer that follows it.
  always_comb begin
    sel_addr  = '0;
    sel_wonly = 1'b0;
    sel_wdata = '0;
    ptr_next  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        sel_addr.x = req_x[i*COORD_W +: COORD_W];
        sel_addr.y = req_y[i*COORD_W +: COORD_W];
        sel_wonly  = req_wonly[i];
        sel_wdata  = cmd_wdata[i*DATA_W +: DATA_W];
        ptr_next   = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    any_req    = |req;
    sel_in_map = in_map(sel_addr, MAPA_WIDTH, MAPA_HEIGHT);
  end

  // Only the granted requester's command lines are looked at.
  always_comb begin
    hold_commit = |(cmd_commit & grant);
    hold_abort  = |(cmd_abort & grant);
    hold_wdata  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) hold_wdata = cmd_wdata[i*DATA_W +: DATA_W];
    end
  end

`ifdef MAP_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] hold_cnt;

  // Cycles spent in HOLD; zero on the first HOLD cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state != HOLD) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  assign hold_expired = (hold_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign hold_expired = 1'b0;
`endif

  // Transaction FSM; every output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      lat_addr       <= '0;
      grant          <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      done           <= '0;
      err            <= '0;
      update_renable <= 1'b0;
      update_rx      <= '0;
      update_ry      <= '0;
      update_wenable <= 1'b0;
      update_wx      <= '0;
      update_wy      <= '0;
      update_wdata   <= '0;
    end else begin
      update_renable <= 1'b0;
      update_wenable <= 1'b0;
      done           <= '0;
      err            <= '0;
      case (state)
        IDLE: begin
          grant <= '0;
          if (any_req) begin
            ptr      <= ptr_next;
            lat_addr <= sel_addr;
            if (!sel_in_map) begin
              err <= pick;
            end else begin
              grant <= pick;
              if (sel_wonly) begin
                state          <= WR;
                update_wenable <= 1'b1;
                update_wx      <= sel_addr.x;
                update_wy      <= sel_addr.y;
                update_wdata   <= sel_wdata;
                done           <= pick;
              end else begin
                state          <= RD;
                update_renable <= 1'b1;
                update_rx      <= sel_addr.x;
                update_ry      <= sel_addr.y;
              end
            end
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          rsp_data  <= update_rdata;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          // Abort takes precedence over a simultaneous commit.
          if (hold_abort) begin
            rsp_valid <= 1'b0;
            done      <= grant;
            state     <= END;
          end else if (hold_commit) begin
            rsp_valid      <= 1'b0;
            done           <= grant;
            update_wenable <= 1'b1;
            update_wx      <= lat_addr.x;
            update_wy      <= lat_addr.y;
            update_wdata   <= hold_wdata;
            state          <= WR;
          end else if (hold_expired) begin
            rsp_valid <= 1'b0;
            done      <= grant;
            err       <= grant;
            state     <= END;
          end
        end
        WR, END: begin
          grant <= '0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
